alu_rs: RTL
===========

# alu_rs

Reservation station for the integer ALU. Buffers renamed instructions from dispatch, captures missing operands from the two CDB broadcast buses (ALU and LSB), selects one fully ready entry per cycle, and drives the registered operand bundle into the combinational ALU, which then broadcasts its result on the ALU CDB. It sits between the decode/dispatch stage and the ALU.

## Interface
- RS_SIZE, 8, number of entries; power of two.
- ROB_IDX_W, 4, ROB tag width.
- OPT_W, 6, internal opcode width, the `INST_OPT` encoding.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (rst=0 resets).
- rdy  in  1  global ready; 0 freezes all state.
- flush  in  1  ROB misprediction clear.
- dsp_en  in  1  dispatch valid.
- dsp_opt  in  OPT_W  opcode.
- dsp_val1, dsp_val2  in  32  operand values; valid only when the matching ready bit is 1.
- dsp_rdy1, dsp_rdy2  in  1  operand is ready.
- dsp_q1, dsp_q2  in  ROB_IDX_W  producing ROB tag when not ready.
- dsp_imm  in  32  immediate.
- dsp_rob_idx  in  ROB_IDX_W  destination ROB tag.
- rs_full  out  1  all entries busy; combinational from current state.
- cdb_alu_valid, cdb_lsb_valid  in  1  broadcast valid.
- cdb_alu_src, cdb_lsb_src  in  ROB_IDX_W  broadcast tag.
- cdb_alu_val, cdb_lsb_val  in  32  broadcast value.
- alu_en  out  1  issue strobe; registered.
- rs_opt  out  OPT_W  registered.
- rs_val1, rs_val2, rs_imm  out  32  registered.
- rs_rob_idx  out  ROB_IDX_W  registered.

## Operation
- Each entry holds: busy, opt, val1, rdy1, q1, val2, rdy2, q2, imm, rob_idx.
- Priority at each edge: rst, then flush, then !rdy, then normal operation.
- Reset (rst=0): all busy=0, alu_en=0, all rs_* outputs=0, rs_full=0.
- Flush: all busy=0 and alu_en=0 after the edge. Dispatch and CDB data in that cycle are discarded.
- !rdy: no entry changes. alu_en=0 after the edge. rs_* outputs hold.
- Wakeup: for each busy entry with rdyK=0:
  - if cdb_alu_valid and cdb_alu_src==qK, set valK=cdb_alu_val and rdyK=1;
  - else if cdb_lsb_valid and cdb_lsb_src==qK, capture from the LSB bus.
  - Both operands of one entry can wake in the same cycle.
- Dispatch: if dsp_en and !rs_full, write to the lowest-index free entry.
  - An incoming operand with dsp_rdyK=0 whose tag matches a valid CDB in the same cycle is stored as ready with the CDB value (bypass).
  - If dsp_en is asserted while rs_full=1, the dispatch is ignored. Upstream must not do this; the bench flags it.
- Select: the lowest-index entry that is busy with rdy1=rdy2=1, based on state before the edge.
  - The chosen entry's fields are registered onto the rs_* outputs, alu_en=1, and the entry's busy bit clears.
  - With no candidate, alu_en=0 and rs_* hold.
- An entry freed by issue is not available for dispatch in the same cycle, because rs_full reflects pre-edge state.
- Opcode, immediate and values pass through unmodified. Branch and JAL operand formation is the decoder's responsibility.

## Timing
- Dispatch with both operands ready, sampled at edge E: the entry is busy after E and alu_en=1 after E+1. Minimum latency is 1 cycle.
- CDB broadcast waking the last operand at edge E: alu_en=1 after E+1.
- Dispatch-time bypass behaves the same as a CDB wakeup: issue after E+1.
- Throughput is one issue per cycle. alu_en is never held: each issued entry produces exactly one cycle of alu_en.
- The ALU result appears on the CDB combinationally in the cycle alu_en=1. A dependent entry waiting in this station issues the following cycle, giving 2-cycle back-to-back dependency.
- rst asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset, then dispatch ADD with val1=5 and val2=7, both ready, rob_idx=3 → one cycle later alu_en=1, rs_val1=5, rs_val2=7, rs_rob_idx=3; the next cycle alu_en=0.
- Dispatch ADDI with rdy1=0, q1=9, imm=4; two idle cycles → alu_en stays 0. Then cdb_lsb_valid=1, src=9, val=0x10 → the next cycle alu_en=1, rs_val1=0x10, rs_imm=4.
- Dispatch with rdy2=0, q2=2 in the same cycle as cdb_alu_valid=1, src=2, val=0xAA → issue the next cycle with rs_val2=0xAA (bypass).
- Dispatch 8 entries, all waiting on tag 1 → rs_full=1; a 9th dispatch is dropped. Broadcast tag 1 → 8 consecutive alu_en pulses in index order, and rs_full=0 after the first issue.
- Entries 2 and 5 become ready in the same cycle → entry 2 issues first, then entry 5 the next cycle.
- Hold rdy=0 while ready entries exist → alu_en=0 and no entry is lost; after rdy=1, issue resumes. Then assert flush with 3 busy entries → rs_full=0, no further alu_en, and a subsequent dispatch lands in entry 0.

Source files
------------

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers dispatched ops, wakes operands from ALU/LSB CDBs, issues one ready op per cycle.
// Latency: ready-at-dispatch op issues one cycle after it is written; a CDB wakeup issues the cycle after the broadcast.
// Backpressure: rs_full (pre-edge state) blocks dispatch; rdy=0 freezes all entries and suppresses issue.
module alu_rs #(
   parameter int RS_SIZE   = 8,
   parameter int ROB_IDX_W = 4,
   parameter int OPT_W     = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 flush,
   input  logic                 dsp_en,
   input  logic [OPT_W-1:0]     dsp_opt,
   input  logic [31:0]          dsp_val1,
   input  logic [31:0]          dsp_val2,
   input  logic                 dsp_rdy1,
   input  logic                 dsp_rdy2,
   input  logic [ROB_IDX_W-1:0] dsp_q1,
   input  logic [ROB_IDX_W-1:0] dsp_q2,
   input  logic [31:0]          dsp_imm,
   input  logic [ROB_IDX_W-1:0] dsp_rob_idx,
   output logic                 rs_full,
   input  logic                 cdb_alu_valid,
   input  logic [ROB_IDX_W-1:0] cdb_alu_src,
   input  logic [31:0]          cdb_alu_val,
   input  logic                 cdb_lsb_valid,
   input  logic [ROB_IDX_W-1:0] cdb_lsb_src,
   input  logic [31:0]          cdb_lsb_val,
   output logic                 alu_en,
   output logic [OPT_W-1:0]     rs_opt,
   output logic [31:0]          rs_val1,
   output logic [31:0]          rs_val2,
   output logic [31:0]          rs_imm,
   output logic [ROB_IDX_W-1:0] rs_rob_idx
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   typedef struct packed {
      logic                 busy;
      logic [OPT_W-1:0]     opt;
      logic [31:0]          val1;
      logic                 rdy1;
      logic [ROB_IDX_W-1:0] q1;
      logic [31:0]          val2;
      logic                 rdy2;
      logic [ROB_IDX_W-1:0] q2;
      logic [31:0]          imm;
      logic [ROB_IDX_W-1:0] rob_idx;
   } entry_t;

   entry_t             ent [RS_SIZE];
   logic [RS_SIZE-1:0] busy_vec;
   logic [RS_SIZE-1:0] ready_vec;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_vld;
   entry_t             dsp_ent;

   // a tag is produced this cycle if either bus carries it
   function automatic logic cdb_match(input logic [ROB_IDX_W-1:0] q);
      return (cdb_alu_valid && cdb_alu_src == q) || (cdb_lsb_valid && cdb_lsb_src == q);
   endfunction

   // ALU bus wins when both buses carry the same tag
   function automatic logic [31:0] cdb_value(input logic [ROB_IDX_W-1:0] q);
      return (cdb_alu_valid && cdb_alu_src == q) ? cdb_alu_val : cdb_lsb_val;
   endfunction

   // lowest free slot, lowest ready slot, and the dispatch entry with same-cycle CDB bypass
   always_comb begin
      busy_vec  = '0;
      ready_vec = '0;
      free_idx  = '0;
      sel_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         busy_vec[i]  = ent[i].busy;
         ready_vec[i] = ent[i].busy && ent[i].rdy1 && ent[i].rdy2;
         if (!ent[i].busy) free_idx = IDX_W'(i);
         if (ready_vec[i]) sel_idx = IDX_W'(i);
      end
      sel_vld = |ready_vec;

      dsp_ent         = '0;
      dsp_ent.busy    = 1'b1;
      dsp_ent.opt     = dsp_opt;
      dsp_ent.imm     = dsp_imm;
      dsp_ent.rob_idx = dsp_rob_idx;
      dsp_ent.q1      = dsp_q1;
      dsp_ent.q2      = dsp_q2;
      dsp_ent.rdy1    = dsp_rdy1 || cdb_match(dsp_q1);
      dsp_ent.val1    = dsp_rdy1 ? dsp_val1 : cdb_value(dsp_q1);
      dsp_ent.rdy2    = dsp_rdy2 || cdb_match(dsp_q2);
      dsp_ent.val2    = dsp_rdy2 ? dsp_val2 : cdb_value(dsp_q2);
   end

   assign rs_full = &busy_vec;

   // entry wakeup, dispatch write and issue register, with reset > flush > stall priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
         alu_en     <= 1'b0;
         rs_opt     <= '0;
         rs_val1    <= '0;
         rs_val2    <= '0;
         rs_imm     <= '0;
         rs_rob_idx <= '0;
      end else if (flush) begin
         for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
         alu_en <= 1'b0;
      end else if (!rdy) begin
         alu_en <= 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent[i].busy) begin
               if (!ent[i].rdy1 && cdb_match(ent[i].q1)) begin
                  ent[i].val1 <= cdb_value(ent[i].q1);
                  ent[i].rdy1 <= 1'b1;
               end
               if (!ent[i].rdy2 && cdb_match(ent[i].q2)) begin
                  ent[i].val2 <= cdb_value(ent[i].q2);
                  ent[i].rdy2 <= 1'b1;
               end
               if (sel_vld && IDX_W'(i) == sel_idx) ent[i].busy <= 1'b0;
            end
         end
         // the free slot is never busy, so this never collides with the wakeup writes above
         if (dsp_en && !rs_full) ent[free_idx] <= dsp_ent;
         if (sel_vld) begin
            alu_en     <= 1'b1;
            rs_opt     <= ent[sel_idx].opt;
            rs_val1    <= ent[sel_idx].val1;
            rs_val2    <= ent[sel_idx].val2;
            rs_imm     <= ent[sel_idx].imm;
            rs_rob_idx <= ent[sel_idx].rob_idx;
         end else begin
            alu_en <= 1'b0;
         end
      end
   end

endmodule
